// File: rtl/carry_select_adder.sv
// carry_select_adder: registered WIDTH-bit two's-complement/unsigned adder
// built as a carry-select chain of BLOCK-bit ripple blocks.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears all outputs
//   a, b - operands
//   cin  - carry-in
//   sum  - registered (a + b + cin) mod 2^WIDTH
//   cout - registered carry out of bit WIDTH-1
//   of   - registered signed overflow (carry into MSB ^ carry out of MSB)
module carry_select_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  localparam int NBLK = WIDTH / BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_bad_block
    $error("carry_select_adder: WIDTH must be a multiple of BLOCK");
  end

  logic [WIDTH-1:0] sum_c;   // combinational sum
  logic [NBLK:1]    bc;      // selected carry out of each block
  logic             msb_c;   // carry into bit WIDTH-1

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLOCK-1:0] x, y;
    assign x = a[k*BLOCK +: BLOCK];
    assign y = b[k*BLOCK +: BLOCK];

    if (k == 0) begin : g_rc
      // Block 0 sees cin directly, so a single ripple chain suffices.
      logic [BLOCK:0]   c;
      logic [BLOCK-1:0] s;
      always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < BLOCK; i++) begin
          s[i]   = x[i] ^ y[i] ^ c[i];
          c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
      end
      assign sum_c[BLOCK-1:0] = s;
      assign bc[1]            = c[BLOCK];
      if (NBLK == 1) begin : g_last
        assign msb_c = c[BLOCK-1];
      end
    end else begin : g_cs
      // Both carry-in hypotheses are precomputed; the incoming block carry
      // only steers the mux, keeping the critical path one mux per block.
      logic [BLOCK:0]   c0, c1;
      logic [BLOCK-1:0] s0, s1;
      always_comb begin
        c0    = '0;
        c1    = '0;
        s0    = '0;
        s1    = '0;
        c1[0] = 1'b1;
        for (int unsigned i = 0; i < BLOCK; i++) begin
          s0[i]   = x[i] ^ y[i] ^ c0[i];
          c0[i+1] = (x[i] & y[i]) | (c0[i] & (x[i] ^ y[i]));
          s1[i]   = x[i] ^ y[i] ^ c1[i];
          c1[i+1] = (x[i] & y[i]) | (c1[i] & (x[i] ^ y[i]));
        end
      end
      assign sum_c[k*BLOCK +: BLOCK] = bc[k] ? s1 : s0;
      assign bc[k+1]                 = bc[k] ? c1[BLOCK] : c0[BLOCK];
      if (k == NBLK - 1) begin : g_last
        assign msb_c = bc[k] ? c1[BLOCK-1] : c0[BLOCK-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      of   <= 1'b0;
    end else begin
      sum  <= sum_c;
      cout <= bc[NBLK];
      of   <= msb_c ^ bc[NBLK];
    end
  end

endmodule

// File: tb/tb_carry_select_adder.sv
// tb_carry_select_adder: directed and random checks of carry_select_adder
// at WIDTH=32, BLOCK=4, including async reset and one-cycle latency.
module tb_carry_select_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, sum;
  logic        cin, cout, of;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  carry_select_adder #(.WIDTH(32), .BLOCK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .of   (of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] es,
                       input logic ec, input logic eo);
    n_assert++;
    assert (sum === es) else begin
      n_fail++;
      $error("FAIL %s sum: observed %h expected %h", tag, sum, es);
    end
    n_assert++;
    assert (cout === ec) else begin
      n_fail++;
      $error("FAIL %s cout: observed %b expected %b", tag, cout, ec);
    end
    n_assert++;
    assert (of === eo) else begin
      n_fail++;
      $error("FAIL %s of: observed %b expected %b", tag, of, eo);
    end
  endtask

  // Drive operands, let one rising edge capture them, check just after it.
  task automatic step(input string tag, input logic [31:0] va,
                      input logic [31:0] vb, input logic vc,
                      input logic [31:0] es, input logic ec, input logic eo);
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
    check(tag, es, ec, eo);
  endtask

  logic [31:0] ra, rb, es;
  logic        rc, ec, eo;

  initial begin
    rst = 1'b1;
    a   = 32'h1234_5678;
    b   = 32'h0000_0001;
    cin = 1'b1;
    #2;
    check("reset_initial", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step("pos_overflow",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
    step("neg_overflow",   32'h8FFF_FFFF, 32'h8FFF_FFFF, 1'b0, 32'h1FFF_FFFE, 1'b1, 1'b1);
    step("mixed_1",        32'h0000_07AA, 32'hFFFF_FFFF, 1'b0, 32'h0000_07A9, 1'b1, 1'b0);
    step("mixed_2",        32'h0000_0123, 32'hFFFF_F123, 1'b0, 32'hFFFF_F246, 1'b0, 1'b0);
    step("cin_small",      32'h0000_00AF, 32'h0000_00AF, 1'b1, 32'h0000_015F, 1'b0, 1'b0);
    step("cin_full_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    step("ones_plus_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step("neg_no_ovf",     32'hFFFF_F999, 32'h0000_0111, 1'b0, 32'hFFFF_FAAA, 1'b0, 1'b0);
    step("zero_plus_ones", 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step("min_plus_min",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    step("cin_overflow",   32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

    // Inputs changing (or going X) between edges must not disturb outputs.
    a   = 32'h0000_0001;
    b   = 32'h0000_0002;
    #2;
    a   = 'x;
    #2;
    a   = 32'h0000_0005;
    cin = 1'b0;
    #2;
    check("hold_between_edges", 32'h8000_0000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("capture_after_change", 32'h0000_0007, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, away from any clock edge.
    step("pre_reset", 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h0000_3001, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'h0, 1'b0, 1'b0);
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("reset_mid_held", 32'h0, 1'b0, 1'b0);
    #3;
    rst = 1'b0;

    // Back-to-back operands after release, one result per edge.
    step("b2b_0", 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
    step("b2b_1", 32'hF000_0000, 32'h1000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    step("b2b_2", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    step("b2b_3", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      {ec, es} = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      eo = (ra[31] == rb[31]) && (es[31] != ra[31]);
      step("random", ra, rb, rc, es, ec, eo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/carry_select_adder.md
Name: carry_select_adder

Overview:
- Signed/unsigned 32-bit two's-complement adder with carry-in, carry-out and signed-overflow flag.
- Internally a carry-select structure: fixed-size ripple blocks computed for both carry-in values, selected by the incoming block carry.
- Result is captured in an output register, giving one clock of latency.
- Used as the datapath adder in the adder-comparison suite.

Parameters:
- WIDTH, 32: operand and sum width in bits. The design is verified at 32.
- BLOCK, 4: bits per carry-select block. WIDTH must be a multiple of BLOCK.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A (two's complement or unsigned).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered result, equal to (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- of  output  1  registered signed-overflow flag.

Behaviour:
- Reset:
  - rst high asynchronously forces sum=0, cout=0, of=0 regardless of clk.
  - Outputs hold 0 while rst is high.
  - The first capture happens on the first rising clk after rst deasserts.
- Latency: a, b, cin sampled at rising edge N appear on sum/cout/of after edge N. One cycle, fully pipelined, new operands accepted every cycle, no handshake.
- Arithmetic: {cout,sum} = a + b + cin, computed at WIDTH+1 bits unsigned.
- Overflow:
  - of = carry into MSB XOR carry out of MSB.
  - Equivalently: of=1 iff a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
  - cin is included in this determination.
- Structure:
  - Block 0 is a plain ripple-carry adder driven by cin.
  - Each block k>0 has two ripple-carry adders: one with carry-in 0, one with carry-in 1.
  - A 2:1 mux selects that block's sum bits and block carry using the previous block's carry-out.
  - The last block's selected carry is cout.
  - The MSB-internal carry, needed for of, is taken from the selected path of the last block.
- Purely combinational between the input pins and the output register. No state beyond that register.
- Boundary cases:
  - All-ones + all-ones gives sum=0xFFFFFFFE, cout=1, of=0.
  - 0 + 0xFFFFFFFF with cin=0 gives 0xFFFFFFFF, cout=0.
  - Carry propagating across every block boundary (e.g. 0xFFFFFFFF+0+cin=1) must produce sum=0, cout=1, of=0.
- Input X or changes between edges have no effect until the next rising edge.

Test Plan:
- Positive overflow: a=0x7FFFFFFF, b=0x7FFFFFFF, cin=0 -> after 1 clk, sum=0xFFFFFFFE, cout=0, of=1.
- Negative overflow: a=0x8FFFFFFF, b=0x8FFFFFFF, cin=0 -> sum=0x1FFFFFFE, cout=1, of=1.
- Mixed signs, no overflow:
  - a=0x7AA, b=0xFFFFFFFF, cin=0 -> sum=0x7A9, cout=1, of=0.
  - a=0x123, b=0xFFFFF123 -> sum=0xFFFFF246, cout=0, of=0.
- Carry-in use: a=0xAF, b=0xAF, cin=1 -> sum=0x15F, cout=0, of=0. Also a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, of=0 (full block-chain propagation).
- Negative, no overflow: a=0xFFFFFFFF, b=0xFFFFFFFF -> sum=0xFFFFFFFE, cout=1, of=0. Also a=0xFFFFF999, b=0x111 -> sum=0xFFFFFAAA, cout=0, of=0.
- Reset and pipeline:
  - Assert rst mid-stream -> outputs go to 0 immediately, without waiting for clk.
  - Release rst, then apply a new operand each cycle -> each result appears exactly one edge later, back to back.
  - Add 1000 random operands, each checked against a 33-bit reference sum and the sign-rule overflow.
